div_bcd_formatter: RTL and testbench
====================================

# div_bcd_formatter

Sequential binary-to-BCD formatter directly downstream of the 8-bit divider. It captures the divider's 8-bit quotient and 8-bit remainder when the divider finishes and converts both to 3-digit packed BCD for the calculator display path. Conversion uses shift-and-add-3 (double dabble) with both operands converted in parallel under one controller. It runs a START/BUSY/DONE handshake compatible with the divider's START/DONE protocol.

## Interface
- No parameters; widths fixed: 8-bit binary in, 12-bit (3-digit) BCD out.
- CLOCK  input  1  system clock; all state changes on rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- START  input  1  level-sampled request, normally wired to divider DONE; accepted only in IDLE.
- QUOTIENT  input  8  unsigned binary quotient, sampled on the accepting edge.
- REMAINDER  input  8  unsigned binary remainder, sampled on the accepting edge.
- DIVZERO  input  1  divisor-was-zero flag, sampled on the accepting edge.
- Q_BCD  output  12  packed BCD quotient {hundreds, tens, ones}.
- R_BCD  output  12  packed BCD remainder, same packing.
- ERROR  output  1  result of the last completed request was a divide-by-zero.
- BUSY  output  1  conversion in progress.
- DONE  output  1  one-cycle completion pulse.

## Operation
- States: IDLE, SHIFT, with a 3-bit shift counter.
- IDLE, START=1 at a rising edge:
  - Load QUOTIENT and REMAINDER into 8-bit source shift registers.
  - Clear both 12-bit BCD accumulators.
  - Latch DIVZERO into an internal error flag.
  - Set counter=0 and BUSY=1, then go to SHIFT.
- IDLE, START=0: hold. Output registers keep their last values.
- SHIFT, each edge, per operand:
  - Every BCD nibble ≥5 gets +3 (combinational correction).
  - Then shift {accumulator, source} left by 1; the source MSB enters the ones nibble LSB.
  - Counter increments.
- SHIFT, edge where counter=7 (8th shift):
  - Write the final accumulators to Q_BCD/R_BCD.
  - Write the error flag to ERROR.
  - Pulse DONE for one cycle, clear BUSY, return to IDLE.
- Divide-by-zero (latched flag=1): the conversion still runs the full 8 shifts. At completion Q_BCD=R_BCD=12'hFFF and ERROR=1. Otherwise ERROR=0.
- START while BUSY is ignored. Input changes during SHIFT have no effect.
- Arithmetic range: inputs 0..255. Hundreds nibble is 0..2. No BCD nibble ever exceeds 9 at completion.
- Reset (async, any state): go to IDLE. Q_BCD=0, R_BCD=0, ERROR=0, BUSY=0, DONE=0, counter=0, and all internal registers cleared. A conversion in flight is discarded and no DONE is issued.

## Timing
- Edge E0 accepts START. BUSY is high from after E0 until after E8.
- Edges E1..E8 perform the 8 shifts. Q_BCD, R_BCD, ERROR and DONE update at E8.
- DONE is high for exactly the cycle between E8 and E9. Latency is 8 cycles from the accepting edge to DONE.
- Back-to-back: the block is in IDLE during the DONE cycle, so a START sampled at E9 is accepted. Throughput is one result per 9 cycles.
- START held high continuously gives repeated conversions every 9 cycles.
- Outputs are registered only; there is no combinational path from inputs to outputs.
- RESET_N assertion clears outputs immediately, without waiting for a clock edge. The first START is accepted at the first rising edge after RESET_N deasserts.

## Test plan
- Reset then START with QUOTIENT=28, REMAINDER=4 (200/7) -> after 8 cycles: DONE pulse, Q_BCD=12'h028, R_BCD=12'h004, ERROR=0.
- QUOTIENT=255, REMAINDER=0, then QUOTIENT=0, REMAINDER=199 back-to-back (START held high) -> first result 12'h255/12'h000; second result 12'h000/12'h199 exactly 9 cycles after the first DONE.
- DIVZERO=1 with QUOTIENT=8'hFF, REMAINDER=8'h12 -> Q_BCD=R_BCD=12'hFFF, ERROR=1. A following normal request (9/3=3 r0) gives 12'h003/12'h000 and ERROR=0.
- START pulsed at cycles 3 and 5 of an active conversion with different inputs -> ignored. The result matches the originally captured operands and exactly one DONE is seen.
- RESET_N low at shift 4 -> outputs 0 immediately and no DONE. After release, START with 100/50 (2 r0) -> 12'h002/12'h000.
- Exhaustive sweep of QUOTIENT and REMAINDER over 0..255 with a scoreboard -> every output digit is 0..9 and equals the decimal value.

Source files
------------

// File: rtl/div_bcd_formatter.sv
// ============================================================================
// div_bcd_formatter
// ----------------------------------------------------------------------------
// Sequential binary-to-BCD formatter that sits directly after the 8-bit
// divider. When the divider signals completion (wired to start), the block
// captures the quotient and remainder. It then converts both to 3-digit
// packed BCD for the calculator display path. Both operands are converted in
// parallel by shift-and-add-3 (double dabble) under a single controller.
//
// Ports:
//   clk        in   1   system clock, all state changes on the rising edge
//   rst_n      in   1   asynchronous active-low reset
//   start      in   1   level-sampled request, accepted only while idle
//   quotient   in   8   unsigned binary quotient, captured when accepted
//   remainder  in   8   unsigned binary remainder, captured when accepted
//   divzero    in   1   divisor-was-zero flag, captured when accepted
//   q_bcd      out  12  packed BCD quotient  {hundreds, tens, ones}
//   r_bcd      out  12  packed BCD remainder {hundreds, tens, ones}
//   error      out  1   last completed request was a divide-by-zero
//   busy       out  1   conversion in progress
//   done       out  1   one-cycle completion pulse
//
// Timing: the accepting edge is E0. Edges E1..E8 perform the eight shifts.
// Results and done appear at E8. The block is already idle during the done
// cycle, so back-to-back requests complete every 9 cycles.
// ============================================================================
module div_bcd_formatter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  quotient,
    input  logic [7:0]  remainder,
    input  logic        divzero,
    output logic [11:0] q_bcd,
    output logic [11:0] r_bcd,
    output logic        error,
    output logic        busy,
    output logic        done
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t      state;
    logic [2:0]  shift_cnt;
    logic [7:0]  src_q;
    logic [7:0]  src_r;
    logic [11:0] acc_q;
    logic [11:0] acc_r;
    logic        err_flag;

    logic [11:0] adj_q;
    logic [11:0] adj_r;
    logic [11:0] next_q;
    logic [11:0] next_r;

    // With 8-bit inputs the accumulator never carries out of the hundreds
    // nibble. The top corrected bit is therefore always zero and is dropped.
    logic        unused_top_bits;

    // Add 3 to a single BCD digit when it is 5 or more. After the
    // following doubling, the digit then carries correctly into the next one.
    function automatic logic [3:0] dabble_digit(input logic [3:0] digit);
        logic [3:0] result;
        result = digit;
        if (digit >= 4'd5) begin
            result = digit + 4'd3;
        end
        return result;
    endfunction

    // Apply the add-3 correction to all three digits of an accumulator.
    function automatic logic [11:0] dabble_correct(input logic [11:0] acc);
        return {dabble_digit(acc[11:8]),
                dabble_digit(acc[7:4]),
                dabble_digit(acc[3:0])};
    endfunction

    // Combinational half of one double-dabble step for both operands:
    // correct the digits, then shift left with the source MSB entering the
    // ones digit LSB. The register stage below commits this on each SHIFT edge.
    always_comb begin
        adj_q           = dabble_correct(acc_q);
        adj_r           = dabble_correct(acc_r);
        next_q          = {adj_q[10:0], src_q[7]};
        next_r          = {adj_r[10:0], src_r[7]};
        unused_top_bits = adj_q[11] | adj_r[11];
    end

    // Controller and datapath registers. done is a single-cycle pulse, so it
    // defaults low on every edge. On the final (8th) shift the outputs are
    // written straight from the combinational step, not from the
    // accumulator, so the result appears on the same edge that completes it.
    // A divide-by-zero still runs the full eight shifts to keep latency fixed.
    // Only the published value is replaced by the all-ones error pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_cnt <= 3'd0;
            src_q     <= 8'd0;
            src_r     <= 8'd0;
            acc_q     <= 12'd0;
            acc_r     <= 12'd0;
            err_flag  <= 1'b0;
            q_bcd     <= 12'd0;
            r_bcd     <= 12'd0;
            error     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q     <= quotient;
                        src_r     <= remainder;
                        acc_q     <= 12'd0;
                        acc_r     <= 12'd0;
                        err_flag  <= divzero;
                        shift_cnt <= 3'd0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end

                SHIFT: begin
                    acc_q     <= next_q;
                    acc_r     <= next_r;
                    src_q     <= {src_q[6:0], 1'b0};
                    src_r     <= {src_r[6:0], 1'b0};
                    shift_cnt <= shift_cnt + 3'd1;
                    if (shift_cnt == 3'd7) begin
                        if (err_flag) begin
                            q_bcd <= 12'hFFF;
                            r_bcd <= 12'hFFF;
                        end else begin
                            q_bcd <= next_q;
                            r_bcd <= next_r;
                        end
                        error <= err_flag;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_bcd_formatter.sv
// ============================================================================
// tb_div_bcd_formatter
// ----------------------------------------------------------------------------
// Self-checking bench for div_bcd_formatter. A table of directed vectors with
// hand-computed BCD results runs first. Hand-written sequences follow for:
// back-to-back requests with start held high, start pulses during a busy
// conversion, and reset in the middle of a conversion. The run ends with a
// sweep of every quotient and remainder value against a decimal-digit model.
// ============================================================================
module tb_div_bcd_formatter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        divzero;
    logic [11:0] q_bcd;
    logic [11:0] r_bcd;
    logic        error;
    logic        busy;
    logic        done;

    int n_vectors = 0;
    int n_miss    = 0;

    typedef struct {
        logic [7:0]  q;
        logic [7:0]  r;
        logic        dz;
        logic [11:0] exp_q;
        logic [11:0] exp_r;
        logic        exp_err;
    } vec_t;

    vec_t vecs[10];

    div_bcd_formatter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .quotient  (quotient),
        .remainder (remainder),
        .divzero   (divzero),
        .q_bcd     (q_bcd),
        .r_bcd     (r_bcd),
        .error     (error),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so a stuck design can never hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation still running, expected completion");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Decimal reference model: digits by division, independent of double dabble.
    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Called just after a rising edge while the DUT is idle. Presents the
    // operands for exactly one accepting edge (E0), then returns at E0+1.
    task automatic applyStimulus(input logic [7:0] q, input logic [7:0] r,
                                 input logic dz);
        start     = 1'b1;
        quotient  = q;
        remainder = r;
        divzero   = dz;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges until done is seen, bounded to 20 cycles.
    task automatic wait_done(output int cycles, output bit seen);
        cycles = 0;
        seen   = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int cyc;
        bit seen;
        int done_count;
        logic [11:0] cap_q;
        logic [11:0] cap_r;
        logic        cap_err;
        int rv;

        vecs[0] = '{8'd28,  8'd4,   1'b0, 12'h028, 12'h004, 1'b0};
        vecs[1] = '{8'hFF,  8'h12,  1'b1, 12'hFFF, 12'hFFF, 1'b1};
        vecs[2] = '{8'd3,   8'd0,   1'b0, 12'h003, 12'h000, 1'b0};
        vecs[3] = '{8'd99,  8'd9,   1'b0, 12'h099, 12'h009, 1'b0};
        vecs[4] = '{8'd100, 8'd101, 1'b0, 12'h100, 12'h101, 1'b0};
        vecs[5] = '{8'd59,  8'd95,  1'b0, 12'h059, 12'h095, 1'b0};
        vecs[6] = '{8'd150, 8'd249, 1'b0, 12'h150, 12'h249, 1'b0};
        vecs[7] = '{8'd7,   8'd200, 1'b0, 12'h007, 12'h200, 1'b0};
        vecs[8] = '{8'd0,   8'd0,   1'b1, 12'hFFF, 12'hFFF, 1'b1};
        vecs[9] = '{8'd10,  8'd5,   1'b0, 12'h010, 12'h005, 1'b0};

        rst_n     = 1'b0;
        start     = 1'b0;
        quotient  = 8'd0;
        remainder = 8'd0;
        divzero   = 1'b0;
        #12;
        checkOutput("reset_q_bcd", q_bcd, 12'h000);
        checkOutput("reset_r_bcd", r_bcd, 12'h000);
        checkOutput("reset_error", error, 1'b0);
        checkOutput("reset_busy",  busy,  1'b0);
        checkOutput("reset_done",  done,  1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven vectors, including divide-by-zero followed by a
        // normal request that must clear error.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].q, vecs[i].r, vecs[i].dz);
            checkOutput($sformatf("v%0d_busy_after_accept", i), busy, 1'b1);
            wait_done(cyc, seen);
            checkOutput($sformatf("v%0d_done_seen", i), seen, 1'b1);
            checkOutput($sformatf("v%0d_latency", i), cyc, 8);
            checkOutput($sformatf("v%0d_q_bcd", i), q_bcd, vecs[i].exp_q);
            checkOutput($sformatf("v%0d_r_bcd", i), r_bcd, vecs[i].exp_r);
            checkOutput($sformatf("v%0d_error", i), error, vecs[i].exp_err);
            checkOutput($sformatf("v%0d_busy_at_done", i), busy, 1'b0);
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d_done_width", i), done, 1'b0);
        end

        // Back-to-back with start held high. The second operands are presented
        // during the first conversion and captured at E9, in the done cycle.
        start     = 1'b1;
        quotient  = 8'd255;
        remainder = 8'd0;
        divzero   = 1'b0;
        @(posedge clk);
        #1;
        quotient  = 8'd0;
        remainder = 8'd199;
        wait_done(cyc, seen);
        checkOutput("b2b_first_latency", cyc, 8);
        checkOutput("b2b_first_q", q_bcd, 12'h255);
        checkOutput("b2b_first_r", r_bcd, 12'h000);
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("b2b_busy_after_reaccept", busy, 1'b1);
        wait_done(cyc, seen);
        checkOutput("b2b_gap_cycles", cyc + 1, 9);
        checkOutput("b2b_second_q", q_bcd, 12'h000);
        checkOutput("b2b_second_r", r_bcd, 12'h199);
        @(posedge clk);
        #1;

        // start pulses at E3 and E5 carry different operands and must be
        // ignored. Exactly one done is expected, with the original result.
        applyStimulus(8'd123, 8'd45, 1'b0);
        quotient   = 8'd200;
        remainder  = 8'd7;
        divzero    = 1'b1;
        done_count = 0;
        cap_q      = 12'h000;
        cap_r      = 12'h000;
        cap_err    = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            start = (e == 3 || e == 5);
            @(posedge clk);
            #1;
            if (done) begin
                done_count++;
                cap_q   = q_bcd;
                cap_r   = r_bcd;
                cap_err = error;
            end
        end
        start = 1'b0;
        checkOutput("ignore_done_count", done_count, 1);
        checkOutput("ignore_q", cap_q, 12'h123);
        checkOutput("ignore_r", cap_r, 12'h045);
        checkOutput("ignore_error", cap_err, 1'b0);

        // Reset during shift 4. Outputs hold 123/045 beforehand, so the
        // immediate clear is observable.
        divzero = 1'b0;
        applyStimulus(8'd77, 8'd66, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_q_bcd", q_bcd, 12'h000);
        checkOutput("midreset_r_bcd", r_bcd, 12'h000);
        checkOutput("midreset_busy",  busy,  1'b0);
        checkOutput("midreset_done",  done,  1'b0);
        done_count = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk);
            #1;
            if (done) done_count++;
        end
        checkOutput("midreset_no_done", done_count, 0);
        applyStimulus(8'd2, 8'd0, 1'b0);
        wait_done(cyc, seen);
        checkOutput("postreset_done_seen", seen, 1'b1);
        checkOutput("postreset_q", q_bcd, 12'h002);
        checkOutput("postreset_r", r_bcd, 12'h000);
        checkOutput("postreset_error", error, 1'b0);
        @(posedge clk);
        #1;

        // Sweep every quotient. Remainder follows an odd-stride permutation,
        // so it also covers every value 0..255.
        for (int i = 0; i < 256; i++) begin
            rv = (i * 73 + 29) % 256;
            applyStimulus(8'(i), 8'(rv), 1'b0);
            wait_done(cyc, seen);
            checkOutput($sformatf("sweep_done_%0d", i), seen, 1'b1);
            checkOutput($sformatf("sweep_q_%0d", i), q_bcd, to_bcd(i));
            checkOutput($sformatf("sweep_r_%0d", i), r_bcd, to_bcd(rv));
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miss);
        $finish;
    end

endmodule
